// File: rtl/seq_rotl7.sv
// seq_rotl7: multi-cycle 7-bit rotate unit, one bit per clock, with CF/SF/ZF
// flags matching the combinational ALU. Rotates left by B mod 7 so that an
// ALU rotate-right by the same amount is undone.
// Optional feature macro: SEQ_ROTL7_DIR_EN adds a 'dir' input (1 = rotate right).
module seq_rotl7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] A,
  input  logic [6:0] B,
`ifdef SEQ_ROTL7_DIR_EN
  input  logic       dir,
`endif
  output logic       busy,
  output logic       done,
  output logic [6:0] R,
  output logic       CF,
  output logic       SF,
  output logic       ZF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] work;
  logic [2:0] cnt;
  logic [2:0] k_load;
  logic       accept;
  logic       dir_q;

  // Single rotate step; 'right' selects the direction.
  function automatic logic [6:0] rot_step(input logic [6:0] w, input logic right);
    if (right) return {w[0], w[6:1]};
    else       return {w[5:0], w[6]};
  endfunction

  // Bit that wraps around during a step; becomes the carry flag.
  function automatic logic wrap_bit(input logic [6:0] w, input logic right);
    if (right) return w[0];
    else       return w[6];
  endfunction

  // Effective rotate amount; a full turn (any multiple of 7) collapses to 0.
  assign k_load = 3'(B % 7'd7);

  // A request is taken in IDLE and also in DONE, which allows back-to-back use.
  assign accept = start && (state != ROT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (k_load != 3'd0) ? ROT : DONE;
      end
      ROT: begin
        busy = 1'b1;
        if (cnt == 3'd1) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (k_load != 3'd0) ? ROT : DONE;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Work register, remaining count and carry: load on accept, step in ROT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= 7'd0;
      cnt  <= 3'd0;
      CF   <= 1'b0;
    end else if (accept) begin
      work <= A;
      cnt  <= k_load;
      CF   <= 1'b0;
    end else if (state == ROT) begin
      work <= rot_step(work, dir_q);
      CF   <= wrap_bit(work, dir_q);
      cnt  <= cnt - 3'd1;
    end
  end

`ifdef SEQ_ROTL7_DIR_EN
  // Direction is captured with the request so it may change while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dir_q <= 1'b0;
    else if (accept) dir_q <= dir;
  end
`else
  assign dir_q = 1'b0;
`endif

  assign R  = work;
  assign SF = work[6];
  assign ZF = (work == 7'd0);

endmodule

// File: tb/tb_seq_rotl7.sv
// Testbench for seq_rotl7: directed and random requests; expected results are
// queued at issue time and compared by an independent monitor on each done.
module tb_seq_rotl7;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] A;
  logic [6:0] B;
  logic       busy;
  logic       done;
  logic [6:0] R;
  logic       CF;
  logic       SF;
  logic       ZF;
`ifdef SEQ_ROTL7_DIR_EN
  logic       dir;
`endif

  seq_rotl7 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SEQ_ROTL7_DIR_EN
    .dir   (dir),
`endif
    .busy  (busy),
    .done  (done),
    .R     (R),
    .CF    (CF),
    .SF    (SF),
    .ZF    (ZF)
  );

  typedef struct {
    logic [6:0] r;
    logic       cf;
    int         acc;
    int         k;
    int         bbase;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  int   busy_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cycle);
    end
  endtask

  // Reference: rotation by k = b mod 7 as plain shift arithmetic.
  function automatic exp_t model(input logic [6:0] a, input logic [6:0] b, input logic d);
    exp_t e;
    int x, k, y;
    x = int'(a);
    k = int'(b) % 7;
    if (!d) y = ((x << k) | (x >> (7 - k))) & 127;
    else    y = ((x >> k) | (x << (7 - k))) & 127;
    e.r  = 7'(y);
    if (k == 0) e.cf = 1'b0;
    else        e.cf = d ? e.r[6] : e.r[0];
    e.k   = k;
    e.acc = 0;
    e.bbase = 0;
    return e;
  endfunction

  // Monitor: counts busy cycles and checks every done against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy) busy_total <= busy_total + 1;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_done: got done=1 expected no pending request (cycle %0d)", cycle);
        end else begin
          e = exp_q.pop_front();
          check("R", int'(R), int'(e.r));
          check("CF", int'(CF), int'(e.cf));
          check("SF", int'(SF), int'(e.r[6]));
          check("ZF", int'(ZF), (e.r == 7'd0) ? 1 : 0);
          check("latency", cycle - e.acc, e.k);
          check("busy_cycles", busy_total - e.bbase, e.k);
        end
      end
    end
  end

  // Issue one request (call at a falling edge) and wait for its done.
  // poke_at >= 0 raises start again with other operands while busy.
  task automatic run_txn(input logic [6:0] a, input logic [6:0] b, input logic d,
                         input int poke_at);
    exp_t e;
    bit   got;
    e = model(a, b, d);
    start = 1'b1;
    A = a;
    B = b;
`ifdef SEQ_ROTL7_DIR_EN
    dir = d;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 7'($urandom);
    B = 7'($urandom);
`ifdef SEQ_ROTL7_DIR_EN
    dir = ~d;
`endif
    e.acc   = cycle;
    e.bbase = busy_total;
    exp_q.push_back(e);
    got = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (t == poke_at) begin
        start = 1'b1;
        A = 7'h7F;
        B = 7'd1;
      end else if (t == poke_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
  endtask

  initial begin
    logic d;
    int   gap;
    // Reset held with a pending-looking request on the inputs.
    rst_n = 1'b0;
    start = 1'b1;
    A = 7'b1010101;
    B = 7'b0000011;
`ifdef SEQ_ROTL7_DIR_EN
    dir = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_R", int'(R), 0);
    check("rst_CF", int'(CF), 0);
    check("rst_SF", int'(SF), 0);
    check("rst_ZF", int'(ZF), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);

    // Directed cases.
    run_txn(7'b1000001, 7'd1, 1'b0, -1);
    @(negedge clk);
    run_txn(7'b1100001, 7'd2, 1'b0, -1);
    @(negedge clk);
    run_txn(7'b0001000, 7'd3, 1'b0, -1);
    @(negedge clk);
    run_txn(7'b1000001, 7'd7, 1'b0, -1);
    @(negedge clk);
    run_txn(7'b1000001, 7'd10, 1'b0, -1);
    @(negedge clk);
    run_txn(7'b0000000, 7'd5, 1'b0, -1);
    @(negedge clk);
    run_txn(7'b0000000, 7'd5, 1'b0, 1);
    repeat (4) @(negedge clk);
    // Back-to-back including amount 0 and 7*k.
    run_txn(7'b0110011, 7'd6, 1'b0, -1);
    run_txn(7'b0110011, 7'd14, 1'b0, -1);
    run_txn(7'b1110000, 7'd127, 1'b0, -1);
`ifdef SEQ_ROTL7_DIR_EN
    @(negedge clk);
    run_txn(7'b1000001, 7'd1, 1'b1, -1);
    run_txn(7'b0001011, 7'd4, 1'b1, -1);
`endif

    // Random requests with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
`ifdef SEQ_ROTL7_DIR_EN
      d = 1'($urandom);
`else
      d = 1'b0;
`endif
      run_txn(7'($urandom), 7'($urandom), d, -1);
    end

    // Reset in the middle of a rotation: immediate return, no done.
    @(negedge clk);
    start = 1'b1;
    A = 7'b1111111;
    B = 7'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_R", int'(R), 0);
    check("abort_CF", int'(CF), 0);
    check("abort_SF", int'(SF), 0);
    check("abort_ZF", int'(ZF), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_busy_after", int'(busy), 0);
    check("pending_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
